// File: rtl/alu_top.sv
// Single-cycle 32-bit ALU: RV32-style arithmetic, logic, shift and branch compares.
// Results are registered on every soc_clk edge with dat_ready high and held otherwise.
module alu_top (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        dat_ready,
    input  logic [31:0] ALU_dat1,
    input  logic [31:0] ALU_dat2,
    input  logic [4:0]  Instruction_to_ALU,
    output logic [31:0] ALU_out,
    output logic        ALU_overflow,
    output logic        ALU_zero,
    output logic        ALU_con_met,
    output logic        ALU_err,
    output logic        ALU_ready
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_SLL  = 5'b00010;
    localparam logic [4:0] OP_SLT  = 5'b00011;
    localparam logic [4:0] OP_SLTU = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_BEQ  = 5'b01010;
    localparam logic [4:0] OP_BNE  = 5'b01011;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BGE  = 5'b01101;
    localparam logic [4:0] OP_BLTU = 5'b01110;
    localparam logic [4:0] OP_BGEU = 5'b01111;
    localparam logic [4:0] OP_PASS = 5'b10000;

    logic [31:0] a, b, sum, diff;
    logic [4:0]  shamt;
    logic        lt_s, lt_u, eq;

    logic [31:0] out_d, out_q;
    logic        ovf_d, ovf_q;
    logic        con_d, con_q;
    logic        err_d, err_q;
    logic        zero_q, rdy_q;

    assign a     = ALU_dat1;
    assign b     = ALU_dat2;
    assign shamt = b[4:0];
    assign sum   = a + b;
    assign diff  = a - b;
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = (a == b);

    always_comb begin
        out_d = '0;
        ovf_d = 1'b0;
        con_d = 1'b0;
        err_d = 1'b0;
        case (Instruction_to_ALU)
            OP_ADD: begin
                out_d = sum;
                ovf_d = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_SUB: begin
                out_d = diff;
                ovf_d = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            OP_SLL:  out_d = a << shamt;
            OP_SLT:  out_d = {31'b0, lt_s};
            OP_SLTU: out_d = {31'b0, lt_u};
            OP_XOR:  out_d = a ^ b;
            OP_SRL:  out_d = a >> shamt;
            OP_SRA:  out_d = $unsigned($signed(a) >>> shamt);
            OP_OR:   out_d = a | b;
            OP_AND:  out_d = a & b;
            OP_BEQ:  con_d = eq;
            OP_BNE:  con_d = !eq;
            OP_BLT:  con_d = lt_s;
            OP_BGE:  con_d = !lt_s;
            OP_BLTU: con_d = lt_u;
            OP_BGEU: con_d = !lt_u;
            OP_PASS: out_d = b;
            default: err_d = 1'b1;
        endcase
        // Branch results are reported on ALU_out as well as ALU_con_met.
        if (Instruction_to_ALU[4:1] inside {4'b0101, 4'b0110, 4'b0111})
            out_d = {31'b0, con_d};
    end

    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            ovf_q  <= 1'b0;
            con_q  <= 1'b0;
            err_q  <= 1'b0;
            zero_q <= 1'b1;
            rdy_q  <= 1'b0;
        end else if (dat_ready) begin
            out_q  <= out_d;
            ovf_q  <= ovf_d;
            con_q  <= con_d;
            err_q  <= err_d;
            zero_q <= (out_d == 32'd0);
            rdy_q  <= 1'b1;
        end else begin
            rdy_q  <= 1'b0;
        end
    end

    assign ALU_out      = out_q;
    assign ALU_overflow = ovf_q;
    assign ALU_zero     = zero_q;
    assign ALU_con_met  = con_q;
    assign ALU_err      = err_q;
    assign ALU_ready    = rdy_q;

endmodule

// File: tb/tb_alu_top.sv
// Directed bench for alu_top: hand-computed vectors, checked with immediate assertions.
module tb_alu_top;

    logic        soc_clk = 1'b0;
    logic        reset;
    logic        dat_ready;
    logic [31:0] ALU_dat1, ALU_dat2;
    logic [4:0]  Instruction_to_ALU;
    logic [31:0] ALU_out;
    logic        ALU_overflow, ALU_zero, ALU_con_met, ALU_err, ALU_ready;

    int n_cmp = 0;
    int n_err = 0;

    alu_top dut (
        .soc_clk(soc_clk),
        .reset(reset),
        .dat_ready(dat_ready),
        .ALU_dat1(ALU_dat1),
        .ALU_dat2(ALU_dat2),
        .Instruction_to_ALU(Instruction_to_ALU),
        .ALU_out(ALU_out),
        .ALU_overflow(ALU_overflow),
        .ALU_zero(ALU_zero),
        .ALU_con_met(ALU_con_met),
        .ALU_err(ALU_err),
        .ALU_ready(ALU_ready)
    );

    always #5 soc_clk = ~soc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operation, let one rising edge pass, return at the following falling edge.
    task automatic op(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        Instruction_to_ALU = opc;
        ALU_dat1  = a;
        ALU_dat2  = b;
        dat_ready = 1'b1;
        @(posedge soc_clk);
        @(negedge soc_clk);
    endtask

    task automatic chk_all(input string tag, input logic [31:0] o, input logic v,
                           input logic z, input logic c, input logic e, input logic r);
        chk({tag, ".out"}, ALU_out, o);
        chk({tag, ".ovf"}, {31'b0, ALU_overflow}, {31'b0, v});
        chk({tag, ".zero"}, {31'b0, ALU_zero}, {31'b0, z});
        chk({tag, ".con"}, {31'b0, ALU_con_met}, {31'b0, c});
        chk({tag, ".err"}, {31'b0, ALU_err}, {31'b0, e});
        chk({tag, ".rdy"}, {31'b0, ALU_ready}, {31'b0, r});
    endtask

    initial begin
        reset = 1'b1;
        dat_ready = 1'b0;
        ALU_dat1 = '0;
        ALU_dat2 = '0;
        Instruction_to_ALU = '0;
        #1;
        chk_all("reset", 32'h0, 0, 1, 0, 0, 0);
        @(negedge soc_clk);
        @(negedge soc_clk);
        reset = 1'b0;

        op(5'b00000, 32'h7FFF_FFFF, 32'h1);
        chk_all("add_ovf", 32'h8000_0000, 1, 0, 0, 0, 1);
        dat_ready = 1'b0;
        Instruction_to_ALU = 5'b00001;
        @(posedge soc_clk);
        @(negedge soc_clk);
        chk_all("hold", 32'h8000_0000, 1, 0, 0, 0, 0);

        op(5'b00001, 32'd5, 32'd5);
        chk_all("sub_zero", 32'h0, 0, 1, 0, 0, 1);
        op(5'b00001, 32'h8000_0000, 32'h1);
        chk_all("sub_ovf", 32'h7FFF_FFFF, 1, 0, 0, 0, 1);
        op(5'b00000, 32'hFFFF_FFFF, 32'h1);
        chk_all("add_wrap", 32'h0, 0, 1, 0, 0, 1);
        op(5'b00011, 32'hFFFF_FFFF, 32'h1);
        chk("slt", ALU_out, 32'h1);
        op(5'b00100, 32'hFFFF_FFFF, 32'h1);
        chk("sltu", ALU_out, 32'h0);
        op(5'b00111, 32'h8000_0000, 32'h0000_0024);
        chk("sra", ALU_out, 32'hF800_0000);
        op(5'b00110, 32'h8000_0000, 32'h0000_0024);
        chk("srl", ALU_out, 32'h0800_0000);
        op(5'b00010, 32'h0000_0001, 32'hFFFF_FFE3);
        chk("sll", ALU_out, 32'h0000_0008);
        op(5'b00101, 32'hF0F0_1234, 32'h0FF0_FFFF);
        chk("xor", ALU_out, 32'hFF00_EDCB);
        op(5'b01000, 32'hF000_000F, 32'h0F00_00F0);
        chk("or", ALU_out, 32'hFF00_00FF);
        op(5'b01001, 32'hF0F0_FFFF, 32'h0FF0_1234);
        chk("and", ALU_out, 32'h00F0_1234);
        op(5'b10000, 32'h1111_1111, 32'hDEAD_BEEF);
        chk_all("pass", 32'hDEAD_BEEF, 0, 0, 0, 0, 1);

        op(5'b01101, 32'hFFFF_FFFE, 32'd3);
        chk_all("bge", 32'h0, 0, 1, 0, 0, 1);
        op(5'b01111, 32'hFFFF_FFFE, 32'd3);
        chk_all("bgeu", 32'h1, 0, 0, 1, 0, 1);
        op(5'b01010, 32'd7, 32'd7);
        chk_all("beq", 32'h1, 0, 0, 1, 0, 1);
        op(5'b01011, 32'd7, 32'd7);
        chk("bne.con", {31'b0, ALU_con_met}, 32'h0);
        op(5'b01100, 32'hFFFF_FFFE, 32'd3);
        chk("blt.con", {31'b0, ALU_con_met}, 32'h1);
        op(5'b01110, 32'hFFFF_FFFE, 32'd3);
        chk("bltu.con", {31'b0, ALU_con_met}, 32'h0);

        op(5'b11111, 32'd9, 32'd9);
        chk_all("err31", 32'h0, 0, 1, 0, 1, 1);
        op(5'b10001, 32'd9, 32'd9);
        chk("err17", {31'b0, ALU_err}, 32'h1);
        op(5'b00000, 32'd2, 32'd3);
        chk_all("add_after_err", 32'd5, 0, 0, 0, 0, 1);

        // Asynchronous reset between edges, while the add result is still presented.
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 32'h0, 0, 1, 0, 0, 0);
        dat_ready = 1'b0;
        @(negedge soc_clk);
        reset = 1'b0;
        @(posedge soc_clk);
        @(negedge soc_clk);
        chk_all("post_rst_idle", 32'h0, 0, 1, 0, 0, 0);
        op(5'b00000, 32'd10, 32'd20);
        chk_all("post_rst_add", 32'd30, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_top.md
ALU_TOP -- requirements
Module: alu_top

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and opcode width at 5 bits.
REQ-002 The block SHALL have port soc_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port dat_ready, input, 1 bit: operands and opcode are valid; start or continue computation.
REQ-005 The block SHALL have port ALU_dat1, input, 32 bits: operand A (rs1).
REQ-006 The block SHALL have port ALU_dat2, input, 32 bits: operand B (rs2 or immediate).
REQ-007 The block SHALL have port Instruction_to_ALU, input, 5 bits: operation select.
REQ-008 The block SHALL have port ALU_out, output, 32 bits: registered result.
REQ-009 The block SHALL have port ALU_overflow, output, 1 bit: signed overflow of ADD/SUB.
REQ-010 The block SHALL have port ALU_zero, output, 1 bit: ALU_out equals 0.
REQ-011 The block SHALL have port ALU_con_met, output, 1 bit: branch condition true.
REQ-012 The block SHALL have port ALU_err, output, 1 bit: unsupported opcode.
REQ-013 The block SHALL have port ALU_ready, output, 1 bit: outputs valid.

Function
REQ-014 Opcode map SHALL be:
- 00000 ADD: A+B
- 00001 SUB: A-B
- 00010 SLL: A<<B[4:0]
- 00011 SLT: signed A<B -> 1 else 0
- 00100 SLTU: unsigned A<B -> 1 else 0
- 00101 XOR
- 00110 SRL: logical A>>B[4:0]
- 00111 SRA: arithmetic A>>>B[4:0]
- 01000 OR
- 01001 AND
- 01010 BEQ
- 01011 BNE
- 01100 BLT (signed)
- 01101 BGE (signed)
- 01110 BLTU
- 01111 BGEU
- 10000 PASS: out=B
REQ-015 ADD/SUB SHALL wrap modulo 2^32; ALU_overflow=1 only for ADD/SUB when the signed result overflows (operands same sign and result sign differs for ADD; operands different sign and result sign differs from A for SUB), else 0.
REQ-016 Shift ops SHALL use only B[4:0]; B[31:5] ignored.
REQ-017 Branch ops (01010-01111) SHALL set ALU_con_met to the comparison result and ALU_out={31'b0,con_met}; non-branch ops SHALL drive ALU_con_met=0.
REQ-018 Opcodes 10001-11111 SHALL produce ALU_err=1, ALU_out=0, ALU_overflow=0, ALU_con_met=0; valid opcodes SHALL produce ALU_err=0.
REQ-019 ALU_zero SHALL equal (registered ALU_out==0) for every opcode, including error case.
REQ-020 On each rising edge with dat_ready=1, all result outputs SHALL register the function of current inputs and ALU_ready SHALL be set to 1 (latency: one edge).
REQ-021 On each rising edge with dat_ready=0, ALU_ready SHALL be cleared to 0 and other outputs SHALL hold their values.
REQ-022 While dat_ready stays high, the block SHALL recompute every edge; input changes appear after the next edge.
REQ-023 Computation SHALL be combinational from inputs to the output registers; no multi-cycle state machine.

Reset
REQ-024 reset=1 SHALL immediately (asynchronously) force ALU_out=0, ALU_ready=0, ALU_overflow=0, ALU_con_met=0, ALU_err=0, ALU_zero=1 (consistent with ALU_out=0), regardless of clock.
REQ-025 Reset asserted mid-operation SHALL discard the pending result; after release the first edge with dat_ready=1 produces a fresh result.

Verification
REQ-026 ADD A=0x7FFFFFFF, B=1, dat_ready=1 for one edge -> ALU_out=0x80000000, ALU_overflow=1, ALU_zero=0, ALU_ready=1; next edge with dat_ready=0 -> ALU_ready=0, ALU_out held.
REQ-027 SUB A=5, B=5 -> ALU_out=0, ALU_zero=1, ALU_overflow=0; SLT A=0xFFFFFFFF, B=1 -> ALU_out=1; SLTU same operands -> ALU_out=0.
REQ-028 SRA A=0x80000000, B=0x00000024 -> ALU_out=0xF8000000 (shamt 4); SRL same -> 0x08000000.
REQ-029 BGE A=0xFFFFFFFE, B=3 -> ALU_con_met=0; BGEU same -> ALU_con_met=1, ALU_out=1; BEQ A=B=7 -> con_met=1.
REQ-030 Opcode 11111 -> ALU_err=1, ALU_out=0, ALU_zero=1; then opcode 00000 A=2,B=3 -> ALU_err=0, ALU_out=5.
REQ-031 Assert reset between clock edges while ALU_ready=1 and ALU_out=5 -> all outputs cleared immediately (ALU_zero=1) without a clock edge.
